// File: rtl/fetch_ram_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ram_pkg
// Shared constants and types for the fetch-stage table RAM port controller
// (ram_sp_ctrl) and its write queue (ram_wq).
//   - table geometry (entry width, entry count, index width, clear value)
//   - write-queue geometry
//   - controller state encoding
//   - write-queue entry type
// ---------------------------------------------------------------------------
package fetch_ram_pkg;

    localparam int unsigned DATAWIDTH = 64;
    localparam int unsigned INDEXSIZE = 256;
    localparam int unsigned LOGINDEX  = 8;
    localparam int unsigned WQDEPTH   = 4;
    localparam int unsigned LOGWQ     = 2;

    localparam logic [DATAWIDTH-1:0] INITVALUE = {DATAWIDTH{1'b0}};

    // Sweep counter value of the final entry; the counter is one bit wider
    // than the index so it can step past the table end without wrapping.
    localparam logic [LOGINDEX:0] SWEEP_LAST = (LOGINDEX+1)'(INDEXSIZE - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [LOGINDEX-1:0]  index;
        logic [DATAWIDTH-1:0] data;
    } wq_entry_t;

    // Circular pointer advance for the write queue.
    function automatic logic [LOGWQ-1:0] wq_ptr_inc(input logic [LOGWQ-1:0] ptr);
        return ptr + {{(LOGWQ-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ram_wq.sv
// ---------------------------------------------------------------------------
// ram_wq
// WQDEPTH-entry FIFO of pending table updates with a youngest-match lookup
// used to forward not-yet-written data to reads.
// Ports:
//   clk             clock
//   clr_i           synchronous clear (empties the queue)
//   enq_i           push {enq_index_i, enq_data_i}; ignored when full
//   deq_i           pop head; ignored when empty
//   lookup_index_i  index searched among valid entries
//   full_o/empty_o  occupancy flags (state before this cycle's push/pop)
//   head_index_o    index of the oldest entry
//   head_data_o     data of the oldest entry
//   hit_o           some valid entry matches lookup_index_i
//   hit_data_o      data of the youngest matching entry
// ---------------------------------------------------------------------------
module ram_wq
    import fetch_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 enq_i,
    input  logic [LOGINDEX-1:0]  enq_index_i,
    input  logic [DATAWIDTH-1:0] enq_data_i,
    input  logic                 deq_i,
    input  logic [LOGINDEX-1:0]  lookup_index_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [LOGINDEX-1:0]  head_index_o,
    output logic [DATAWIDTH-1:0] head_data_o,
    output logic                 hit_o,
    output logic [DATAWIDTH-1:0] hit_data_o
);

    localparam logic [LOGWQ:0] COUNT_FULL = (LOGWQ+1)'(WQDEPTH);

    wq_entry_t      mem_q [WQDEPTH];
    logic [LOGWQ-1:0] head_q;
    logic [LOGWQ-1:0] tail_q;
    logic [LOGWQ:0]   count_q;
    logic             enq_ok_s;
    logic             deq_ok_s;

    assign full_o       = (count_q == COUNT_FULL);
    assign empty_o      = (count_q == {(LOGWQ+1){1'b0}});
    assign enq_ok_s     = enq_i && !full_o;
    assign deq_ok_s     = deq_i && !empty_o;
    assign head_index_o = mem_q[head_q].index;
    assign head_data_o  = mem_q[head_q].data;

    // Queue storage, pointers and occupancy count.
    // Push only when not full and pop only when not empty, so head and tail
    // never name the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            head_q  <= {LOGWQ{1'b0}};
            tail_q  <= {LOGWQ{1'b0}};
            count_q <= {(LOGWQ+1){1'b0}};
            for (int i = 0; i < WQDEPTH; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else begin
            if (deq_ok_s) begin
                mem_q[head_q].valid <= 1'b0;
                head_q              <= wq_ptr_inc(head_q);
            end
            if (enq_ok_s) begin
                mem_q[tail_q].valid <= 1'b1;
                mem_q[tail_q].index <= enq_index_i;
                mem_q[tail_q].data  <= enq_data_i;
                tail_q              <= wq_ptr_inc(tail_q);
            end
            case ({enq_ok_s, deq_ok_s})
                2'b10:   count_q <= count_q + {{LOGWQ{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{LOGWQ{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

    // Youngest-match search: walk from oldest to youngest so the last match
    // found is the most recent update to that index.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = {DATAWIDTH{1'b0}};
        for (int i = 0; i < WQDEPTH; i++) begin
            if (mem_q[head_q + LOGWQ'(i)].valid &&
                (mem_q[head_q + LOGWQ'(i)].index == lookup_index_i)) begin
                hit_o      = 1'b1;
                hit_data_o = mem_q[head_q + LOGWQ'(i)].data;
            end else begin
                hit_o      = hit_o;
                hit_data_o = hit_data_o;
            end
        end
    end

endmodule

// File: rtl/ram_sp_ctrl.sv
// ---------------------------------------------------------------------------
// ram_sp_ctrl
// Shares the single port of the fetch-stage table RAM between a
// combinational lookup, a queued update path and a clear sweep that writes
// INITVALUE to every entry, one per cycle, after reset or flush_in.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   flush_in                      restart the sweep, discard queued updates
//   rd_req_in/rd_index_in         lookup request
//   rd_grant_out/rd_data_out      lookup served this cycle / its data
//   wr_req_in/wr_index_in/
//   wr_data_in                    update request
//   wr_ready_out                  update accepted at this edge
//   busy_out                      clear sweep in progress
//   ram_we_out/ram_index_out/
//   ram_data_out                  RAM port drive
//   ram_data_in                   RAM combinational read data
// ---------------------------------------------------------------------------
module ram_sp_ctrl
    import fetch_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_in,
    input  logic                 rd_req_in,
    input  logic [LOGINDEX-1:0]  rd_index_in,
    output logic                 rd_grant_out,
    output logic [DATAWIDTH-1:0] rd_data_out,
    input  logic                 wr_req_in,
    input  logic [LOGINDEX-1:0]  wr_index_in,
    input  logic [DATAWIDTH-1:0] wr_data_in,
    output logic                 wr_ready_out,
    output logic                 busy_out,
    output logic                 ram_we_out,
    output logic [LOGINDEX-1:0]  ram_index_out,
    output logic [DATAWIDTH-1:0] ram_data_out,
    input  logic [DATAWIDTH-1:0] ram_data_in
);

    state_e              state_q, state_d;
    logic [LOGINDEX:0]   cnt_q, cnt_d;

    logic                wq_clr_s;
    logic                wq_enq_s;
    logic                wq_deq_s;
    logic                wq_full_s;
    logic                wq_empty_s;
    logic [LOGINDEX-1:0] wq_head_index_s;
    logic [DATAWIDTH-1:0] wq_head_data_s;
    logic                wq_hit_s;
    logic [DATAWIDTH-1:0] wq_hit_data_s;

    assign wq_clr_s = reset || flush_in;
    // An update arriving with a flush is dropped along with the queue.
    assign wq_enq_s = wr_req_in && wr_ready_out && !flush_in;

    ram_wq u_wq (
        .clk            (clk),
        .clr_i          (wq_clr_s),
        .enq_i          (wq_enq_s),
        .enq_index_i    (wr_index_in),
        .enq_data_i     (wr_data_in),
        .deq_i          (wq_deq_s),
        .lookup_index_i (rd_index_in),
        .full_o         (wq_full_s),
        .empty_o        (wq_empty_s),
        .head_index_o   (wq_head_index_s),
        .head_data_o    (wq_head_data_s),
        .hit_o          (wq_hit_s),
        .hit_data_o     (wq_hit_data_s)
    );

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {(LOGINDEX+1){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one entry per cycle, leave CLEAR after the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_in) begin
            state_d = ST_CLEAR;
            cnt_d   = {(LOGINDEX+1){1'b0}};
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_d = cnt_q + {{LOGINDEX{1'b0}}, 1'b1};
                    if (cnt_q == SWEEP_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_CLEAR;
                    cnt_d   = {(LOGINDEX+1){1'b0}};
                end
            endcase
        end
    end

    // Port arbitration and output muxing. A full queue must drain before a
    // read so the update path can never stall indefinitely. Queue writes are
    // held off during a flush cycle so discarded updates never reach the RAM.
    always_comb begin
        ram_we_out    = 1'b0;
        ram_index_out = rd_index_in;
        ram_data_out  = INITVALUE;
        rd_grant_out  = 1'b0;
        rd_data_out   = {DATAWIDTH{1'b0}};
        wr_ready_out  = 1'b0;
        busy_out      = 1'b1;
        wq_deq_s      = 1'b0;
        if (reset) begin
            busy_out = 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ram_we_out    = 1'b1;
                    ram_index_out = cnt_q[LOGINDEX-1:0];
                    ram_data_out  = INITVALUE;
                    busy_out      = 1'b1;
                end
                ST_RUN: begin
                    busy_out     = 1'b0;
                    wr_ready_out = !wq_full_s;
                    if (wq_full_s && !flush_in) begin
                        wq_deq_s      = 1'b1;
                        ram_we_out    = 1'b1;
                        ram_index_out = wq_head_index_s;
                        ram_data_out  = wq_head_data_s;
                    end else if (rd_req_in) begin
                        rd_grant_out = 1'b1;
                        rd_data_out  = wq_hit_s ? wq_hit_data_s : ram_data_in;
                    end else if (!wq_empty_s && !flush_in) begin
                        wq_deq_s      = 1'b1;
                        ram_we_out    = 1'b1;
                        ram_index_out = wq_head_index_s;
                        ram_data_out  = wq_head_data_s;
                    end else begin
                        ram_we_out = 1'b0;
                    end
                end
                default: begin
                    busy_out = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_sp_ctrl.md
# ram_sp_ctrl

Port controller for the fetch-stage single-port table RAM (`ram_sp`). It shares the one RAM port between three users:
- a combinational lookup requester (read);
- a buffered update requester (write, through a small write queue);
- an internal clear sequencer that sweeps every entry to `INITVALUE` after reset or on `flush_in`.

The controller replaces the reset-time bulk initialisation with a sequential one-entry-per-cycle sweep. It sits between the fetch predictor logic and `ram_sp`, and drives `ram_sp` with `reset` tied low.

## Interface
- `DATAWIDTH`, 64, entry width
- `INDEXSIZE`, 256, number of entries
- `LOGINDEX`, 8, index width
- `INITVALUE`, 0, value written by the clear sweep
- `WQDEPTH`, 4, write-queue entries
- `LOGWQ`, 2, log2(`WQDEPTH`)

Ports:
- `clk` in 1: single clock; all state on the rising edge
- `reset` in 1: synchronous, active-high
- `flush_in` in 1: pulse; restarts the clear sweep and discards queued writes
- `rd_req_in` in 1: lookup request
- `rd_index_in` in `LOGINDEX`: lookup index
- `rd_grant_out` out 1: lookup served this cycle
- `rd_data_out` out `DATAWIDTH`: lookup data, valid when `rd_grant_out`=1
- `wr_req_in` in 1: update request
- `wr_index_in` in `LOGINDEX`: update index
- `wr_data_in` in `DATAWIDTH`: update data
- `wr_ready_out` out 1: update accepted at this edge if `wr_req_in`=1
- `busy_out` out 1: clear sweep in progress
- `ram_we_out` out 1: to `ram_sp` `we_in`
- `ram_index_out` out `LOGINDEX`: to `ram_sp` `index_in`
- `ram_data_out` out `DATAWIDTH`: to `ram_sp` `data_in`
- `ram_data_in` in `DATAWIDTH`: from `ram_sp` `data_out` (combinational read)

## Operation
- **States:** CLEAR, RUN.
- **Reset:** state=CLEAR, clear counter=0, queue empty. While `reset`=1, outputs are forced: `ram_we_out`=0, `rd_grant_out`=0, `wr_ready_out`=0, `busy_out`=1, `rd_data_out`=0.
- **CLEAR:**
  - Drives `ram_we_out`=1, `ram_index_out`=counter, `ram_data_out`=`INITVALUE`. Counter increments each cycle.
  - The counter is `LOGINDEX`+1 bits wide and never wraps.
  - When counter = `INDEXSIZE`-1, the next state is RUN.
  - `rd_grant_out`=0, `wr_ready_out`=0, `busy_out`=1.
- **RUN** has one port action per cycle, in this priority order:
  1. Queue full: dequeue the head and write it to the RAM. A pending read is not granted.
  2. `rd_req_in`: read. `ram_we_out`=0, `ram_index_out`=`rd_index_in`, `rd_grant_out`=1.
  3. Queue non-empty: dequeue the head and write it.
  4. Otherwise idle: `ram_we_out`=0, `ram_index_out`=`rd_index_in`.
- **Write acceptance:** `wr_ready_out` = RUN && !full, evaluated before any same-cycle dequeue. Enqueue and dequeue in the same cycle are both allowed. Writes to the RAM drain in FIFO order.
- **Forwarding:**
  - On a granted read, `rd_data_out` is the data of the youngest valid queue entry whose index equals `rd_index_in`. If no entry matches, it is `ram_data_in`.
  - An update enqueued in the same cycle as the read is not forwarded; it becomes visible from the next cycle.
- **`flush_in` (RUN or CLEAR):** next state CLEAR, counter=0, queue emptied. A same-cycle enqueue is dropped.
- **Priority:** `reset` overrides `flush_in`.

## Timing
- After reset deasserts, the first cycle writes index 0, and cycle `INDEXSIZE`-1 writes the last index. RUN begins `INDEXSIZE` cycles after reset deassertion, which is when `busy_out` falls.
- Read latency is 0 cycles: grant and data are combinational in the request cycle.
- Write is accepted at the edge. The earliest RAM write is the next cycle if no read competes. A read that sees a full queue is granted one cycle later at worst.
- `flush_in` in RUN costs `INDEXSIZE` cycles of `busy_out`=1, starting the next cycle.

## Structure
- Package `fetch_ram_pkg` holds:
  - the state encoding (CLEAR=0, RUN=1);
  - the write-queue entry type {valid, index[`LOGINDEX`], data[`DATAWIDTH`]}.
- Sub-module `ram_wq`: a `WQDEPTH`-entry FIFO with head/tail pointers, full/empty flags, synchronous clear, and a youngest-match lookup port (hit + data) for forwarding.
- The top holds the state register, clear counter, arbitration and output muxing.
- `ram_sp` is instantiated by the parent, not inside this block.

## Test plan
- **Reset sweep:** reset for 3 cycles, then release. Check `ram_we_out`=1 with indices 0..255 and data 0 on consecutive cycles, `busy_out`=1 for exactly 256 cycles, then `busy_out`=0 and `wr_ready_out`=1.
- **Arbitration:** RUN, queue empty. Write (idx 5, 0xAA) at cycle t with `rd_req_in`=1 (idx 9) held for 3 cycles. Check reads granted at t..t+2, the write reaches the RAM at t+3, and the read returns 0xAA at idx 5 once drained.
- **Full queue:** enqueue 4 writes back-to-back with `rd_req_in` held. Check `wr_ready_out`=0 on the cycle after the 4th enqueue, the read is denied in that cycle, the head (first write) goes to the RAM, and `wr_ready_out`=1 the next cycle.
- **Forwarding:** enqueue idx 7=0x11, then idx 7=0x22, while reads are continuously granted, then read idx 7. Check `rd_data_out`=0x22 with `ram_data_in` still old. After the drain, the RAM holds 0x22.
- **Flush in RUN:** 2 writes queued, pulse `flush_in`. Check the queue is discarded (no writes to the RAM), the 256-cycle sweep is observed, and idx 7 reads `INITVALUE` afterwards.
- **Flush during CLEAR:** pulse `flush_in` at sweep index 100. Check the next cycle writes index 0 again and `busy_out` stays high for 256 more cycles.
